// File: rtl/prio_pkg.sv
// -----------------------------------------------------------------------------
// prio_pkg
//   Shared definitions for the priority-encoder / service-controller pair.
//   - 2-bit request codes produced by the upstream priority encoder
//   - service controller FSM state encoding
//   - helper deciding whether a new code preempts the latched one
// -----------------------------------------------------------------------------
package prio_pkg;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_D1   = 2'b01;
    localparam logic [1:0] CODE_D2   = 2'b10;
    localparam logic [1:0] CODE_D3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ASSERT = 2'b01,
        HOLD   = 2'b10
    } state_t;

    // Codes are ordered by priority, so a plain unsigned compare decides
    // preemption. CODE_NONE can never preempt anything.
    function automatic logic code_preempts(input logic [1:0] new_code,
                                           input logic [1:0] cur_code);
        return (new_code > cur_code);
    endfunction

endpackage

// File: rtl/prio_service_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset, count -> 0
//     clear  - synchronous clear to 0 (wins over inc)
//     inc    - increment by one unless already saturated
//     count  - current count value (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prio_service_ctrl.sv
// -----------------------------------------------------------------------------
// prio_service_ctrl
//   Consumer of the 3-input priority encoder code {y,x}. Latches a request,
//   raises irq with the latched code until acked, lets higher codes preempt,
//   abandons an unanswered request after TIMEOUT cycles, and enforces a
//   HOLD_CYCLES cooldown (irq low) between services. Counts acked requests
//   with a saturating counter.
//   Ports:
//     clk         - rising-edge clock
//     rst_n       - asynchronous active-low reset
//     y, x        - encoder code MSB/LSB, synchronous to clk
//     ack         - service acknowledge, only looked at while irq is high
//     irq         - request outstanding (registered)
//     irq_code    - latched code being serviced, valid while irq=1
//     busy        - controller not idle (registered)
//     timeout_err - one-cycle pulse when a request is abandoned
//     served_cnt  - number of acked requests, saturating
// -----------------------------------------------------------------------------
module prio_service_ctrl #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y,
    input  logic             x,
    input  logic             ack,
    output logic             irq,
    output logic [1:0]       irq_code,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] served_cnt
);

    import prio_pkg::*;

    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state_q,       state_d;
    logic [1:0]         code_q,        code_d;
    logic [1:0]         irq_code_q,    irq_code_d;
    logic               irq_q,         irq_d;
    logic               busy_q,        busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [TMO_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q,    hold_cnt_d;
    logic               served_inc;

    always_comb begin
        code_d        = {y, x};
        state_d       = state_q;
        irq_code_d    = irq_code_q;
        tmo_cnt_d     = tmo_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = 1'b0;
        served_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (code_q != CODE_NONE) begin
                    state_d    = ASSERT;
                    irq_code_d = code_q;
                    tmo_cnt_d  = '0;
                end
            end

            ASSERT: begin
                // Ack is checked first so it beats a same-cycle preempt or timeout.
                if (ack) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    served_inc = 1'b1;
                end else if (code_preempts(code_q, irq_code_q)) begin
                    irq_code_d = code_q;
                    tmo_cnt_d  = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            HOLD: begin
                // Leaving the cooldown applies the IDLE entry decision on the
                // same edge, so a pending code re-raises irq right after
                // exactly HOLD_CYCLES low cycles and nothing is lost.
                if (hold_cnt_q == HOLD_LAST) begin
                    if (code_q != CODE_NONE) begin
                        state_d    = ASSERT;
                        irq_code_d = code_q;
                        tmo_cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        irq_d  = (state_d == ASSERT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            code_q        <= CODE_NONE;
            irq_code_q    <= CODE_NONE;
            irq_q         <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            irq_code_q    <= irq_code_d;
            irq_q         <= irq_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_served_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (served_inc),
        .count (served_cnt)
    );

    assign irq         = irq_q;
    assign irq_code    = irq_code_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prio_service_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prio_service_ctrl
//   Directed bench for prio_service_ctrl. The upstream priority encoder is
//   represented by a small function turning {d3,d2,d1} into {y,x}. Each step
//   pushes the expected post-edge outputs into a scoreboard queue, clocks the
//   design, then pops and compares. A second instance with CNT_W=2 shares the
//   stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_prio_service_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       y, x, ack;
    logic       irq, busy, timeout_err;
    logic [1:0] irq_code;
    logic [7:0] served_cnt;
    logic       irq2, busy2, timeout_err2;
    logic [1:0] irq_code2;
    logic [1:0] served_cnt2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       irq;
        logic [1:0] code;
        logic       busy;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    prio_service_ctrl #(.HOLD_CYCLES(2), .TIMEOUT(15), .CNT_W(8)) dut (
        .clk (clk), .rst_n (rst_n), .y (y), .x (x), .ack (ack),
        .irq (irq), .irq_code (irq_code), .busy (busy),
        .timeout_err (timeout_err), .served_cnt (served_cnt)
    );

    prio_service_ctrl #(.HOLD_CYCLES(2), .TIMEOUT(15), .CNT_W(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .y (y), .x (x), .ack (ack),
        .irq (irq2), .irq_code (irq_code2), .busy (busy2),
        .timeout_err (timeout_err2), .served_cnt (served_cnt2)
    );

    // Upstream priority encoder: d3 > d2 > d1.
    function automatic logic [1:0] enc(input logic [2:0] d);
        if (d[2])      return 2'b11;
        else if (d[1]) return 2'b10;
        else if (d[0]) return 2'b01;
        else           return 2'b00;
    endfunction

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk(tag, "irq",         32'(irq),         32'd0);
        chk(tag, "irq_code",    32'(irq_code),    32'd0);
        chk(tag, "busy",        32'(busy),        32'd0);
        chk(tag, "timeout_err", 32'(timeout_err), 32'd0);
        chk(tag, "served_cnt",  32'(served_cnt),  32'd0);
        chk(tag, "served_cnt2", 32'(served_cnt2), 32'd0);
    endtask

    // One clock step: drive encoder inputs and ack, record the outputs that
    // must be visible after the coming edge, then compare them.
    task automatic cyc(input logic [2:0] d, input logic a,
                       input logic e_irq, input logic [1:0] e_code,
                       input logic e_busy, input logic e_err,
                       input int e_cnt, input string tag);
        exp_t e;
        {y, x} = enc(d);
        ack    = a;
        e.tag  = tag;
        e.irq  = e_irq;
        e.code = e_code;
        e.busy = e_busy;
        e.err  = e_err;
        e.cnt  = e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("[%0t] %-12s d=%b ack=%b -> irq=%b code=%b busy=%b err=%b cnt=%0d cnt2=%0d",
                 $time, e.tag, d, a, irq, irq_code, busy, timeout_err, served_cnt, served_cnt2);
        chk(e.tag, "irq",         32'(irq),         32'(e.irq));
        chk(e.tag, "busy",        32'(busy),        32'(e.busy));
        chk(e.tag, "timeout_err", 32'(timeout_err), 32'(e.err));
        chk(e.tag, "served_cnt",  32'(served_cnt),  32'(e.cnt));
        chk(e.tag, "served_cnt2", 32'(served_cnt2), 32'((e.cnt > 3) ? 3 : e.cnt));
        if (e.irq) chk(e.tag, "irq_code", 32'(irq_code), 32'(e.code));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        y     = 1'b0;
        x     = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: d1 request, ack, 2-cycle cooldown
        cyc(3'b001, 0, 0, 2'b00, 0, 0, 0, "t1_latch");
        cyc(3'b000, 0, 1, 2'b01, 1, 0, 0, "t1_irq");
        cyc(3'b000, 1, 0, 2'b01, 1, 0, 1, "t1_ack");
        cyc(3'b000, 0, 0, 2'b01, 1, 0, 1, "t1_hold");
        cyc(3'b000, 0, 0, 2'b01, 0, 0, 1, "t1_idle");

        // 2: d1 held, no ack -> 15 high cycles, timeout pulse, re-assert
        cyc(3'b001, 0, 0, 2'b00, 0, 0, 1, "t2_latch");
        for (int i = 0; i < 15; i++) cyc(3'b001, 0, 1, 2'b01, 1, 0, 1, "t2_hi");
        cyc(3'b001, 0, 0, 2'b01, 1, 1, 1, "t2_tmo");
        cyc(3'b001, 0, 0, 2'b01, 1, 0, 1, "t2_hold");
        cyc(3'b000, 0, 1, 2'b01, 1, 0, 1, "t2_rearm");
        cyc(3'b000, 1, 0, 2'b01, 1, 0, 2, "t2_ack");
        cyc(3'b000, 0, 0, 2'b01, 1, 0, 2, "t2_hold2");
        cyc(3'b000, 0, 0, 2'b01, 0, 0, 2, "t2_idle");

        // 3: d3 preempts d1, timeout restarts from the switch
        cyc(3'b001, 0, 0, 2'b00, 0, 0, 2, "t3_latch");
        for (int i = 0; i < 3; i++) cyc(3'b001, 0, 1, 2'b01, 1, 0, 2, "t3_d1");
        cyc(3'b101, 0, 1, 2'b01, 1, 0, 2, "t3_d3_in");
        for (int i = 0; i < 15; i++) cyc(3'b101, 0, 1, 2'b11, 1, 0, 2, "t3_pre");
        cyc(3'b000, 0, 0, 2'b11, 1, 1, 2, "t3_tmo");
        cyc(3'b000, 0, 0, 2'b11, 1, 0, 2, "t3_hold");
        cyc(3'b000, 0, 0, 2'b11, 0, 0, 2, "t3_idle");

        // 4: ack beats same-cycle d2 preempt; d2 served after cooldown
        cyc(3'b001, 0, 0, 2'b00, 0, 0, 2, "t4_latch");
        cyc(3'b010, 0, 1, 2'b01, 1, 0, 2, "t4_d1");
        cyc(3'b010, 1, 0, 2'b01, 1, 0, 3, "t4_ack_wins");
        cyc(3'b010, 0, 0, 2'b01, 1, 0, 3, "t4_hold");
        cyc(3'b000, 0, 1, 2'b10, 1, 0, 3, "t4_d2");
        cyc(3'b000, 1, 0, 2'b10, 1, 0, 4, "t4_ack2");
        cyc(3'b000, 0, 0, 2'b10, 1, 0, 4, "t4_hold2");
        cyc(3'b000, 0, 0, 2'b10, 0, 0, 4, "t4_idle");

        // 5: async reset mid-ASSERT, then ack in IDLE and HOLD is ignored
        cyc(3'b100, 0, 0, 2'b00, 0, 0, 4, "t5_latch");
        cyc(3'b000, 0, 1, 2'b11, 1, 0, 4, "t5_irq");
        rst_n = 1'b0;
        #1;
        reset_checks("t5_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b000, 1, 0, 2'b00, 0, 0, 0, "t5_ack_idle");
        cyc(3'b001, 0, 0, 2'b00, 0, 0, 0, "t5_latch2");
        cyc(3'b000, 0, 1, 2'b01, 1, 0, 0, "t5_irq2");
        cyc(3'b000, 1, 0, 2'b01, 1, 0, 1, "t5_ack");
        cyc(3'b000, 1, 0, 2'b01, 1, 0, 1, "t5_ack_hold");
        cyc(3'b000, 1, 0, 2'b01, 0, 0, 1, "t5_ack_hold2");

        // 6: four more services -> 5 total; CNT_W=2 copy saturates at 3
        for (int k = 0; k < 4; k++) begin
            cyc(3'b001, 0, 0, 2'b00, 0, 0, 1 + k, "t6_latch");
            cyc(3'b000, 0, 1, 2'b01, 1, 0, 1 + k, "t6_irq");
            cyc(3'b000, 1, 0, 2'b01, 1, 0, 2 + k, "t6_ack");
            cyc(3'b000, 0, 0, 2'b01, 1, 0, 2 + k, "t6_hold");
            cyc(3'b000, 0, 0, 2'b01, 0, 0, 2 + k, "t6_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
